// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D cache line requests onto a 4-beat burst memory port and reassembles read lines.
// Define CACHE_ARB_RR_EN for round-robin arbitration; otherwise the D-cache has fixed priority.
module cache_mem_arbiter #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_dfp_addr,
    input  logic                 i_dfp_read,
    input  logic                 i_dfp_write,
    input  logic [LINE_BITS-1:0] i_dfp_wdata,
    output logic [LINE_BITS-1:0] i_dfp_rdata,
    output logic                 i_dfp_resp,
    input  logic [31:0]          d_dfp_addr,
    input  logic                 d_dfp_read,
    input  logic                 d_dfp_write,
    input  logic [LINE_BITS-1:0] d_dfp_wdata,
    output logic [LINE_BITS-1:0] d_dfp_rdata,
    output logic                 d_dfp_resp,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BEAT, RESP} state_t;

    state_t                 state, state_n;
    logic                   grant_d;
    logic [31:0]            addr_q;
    logic [LINE_BITS-1:0]   wline_q;
    logic [LINE_BITS-1:0]   line_q;
    logic [1:0]             cnt;

    logic                   i_req, d_req, pick_d, sel_write;
    logic [31:0]            sel_addr;
    logic [LINE_BITS-1:0]   sel_wdata;
    logic                   unused_addr_bits;

    // Offset bits within a line carry no meaning for burst transfers.
    assign unused_addr_bits = ^{i_dfp_addr[4:0], d_dfp_addr[4:0]};

    assign i_req = i_dfp_read | i_dfp_write;
    assign d_req = d_dfp_read | d_dfp_write;

`ifdef CACHE_ARB_RR_EN
    logic rr_d;

    always_ff @(posedge clk) begin
        if (rst)
            rr_d <= 1'b1;
        else if (state == RESP)
            rr_d <= ~grant_d;
    end

    assign pick_d = d_req & (~i_req | rr_d);
`else
    assign pick_d = d_req;
`endif

    assign sel_write = pick_d ? d_dfp_write : i_dfp_write;
    assign sel_addr  = pick_d ? d_dfp_addr  : i_dfp_addr;
    assign sel_wdata = pick_d ? d_dfp_wdata : i_dfp_wdata;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_d <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
            line_q  <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        grant_d <= pick_d;
                        addr_q  <= {sel_addr[31:5], 5'b0};
                        wline_q <= sel_wdata;
                        cnt     <= '0;
                    end
                end
                RD_REQ: cnt <= '0;
                RD_WAIT: begin
                    if (bmem_rvalid) begin
                        line_q[int'(cnt)*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
                        cnt <= cnt + 2'd1;
                    end
                end
                WR_BEAT: begin
                    if (bmem_ready)
                        cnt <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        bmem_addr   = addr_q;
        bmem_wdata  = '0;
        i_dfp_resp  = 1'b0;
        d_dfp_resp  = 1'b0;
        i_dfp_rdata = line_q;
        d_dfp_rdata = line_q;
        case (state)
            IDLE: begin
                if (i_req | d_req)
                    state_n = sel_write ? WR_BEAT : RD_REQ;
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready)
                    state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (bmem_rvalid && cnt == 2'd3)
                    state_n = RESP;
            end
            WR_BEAT: begin
                bmem_write = 1'b1;
                bmem_wdata = wline_q[int'(cnt)*BEAT_BITS +: BEAT_BITS];
                if (bmem_ready && cnt == 2'd3)
                    state_n = RESP;
            end
            RESP: begin
                i_dfp_resp = ~grant_d;
                d_dfp_resp = grant_d;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a memory responder driven from the main sequence and
// a scoreboard of expected cache responses (port, aligned address, line).
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_dfp_addr, d_dfp_addr;
    logic         i_dfp_read, i_dfp_write, d_dfp_read, d_dfp_write;
    logic [255:0] i_dfp_wdata, d_dfp_wdata, i_dfp_rdata, d_dfp_rdata;
    logic         i_dfp_resp, d_dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit           d;
        logic [31:0]  addr;
        logic [255:0] line;
    } sb_t;
    sb_t sb[$];

    cache_mem_arbiter #(.LINE_BITS(256), .BEAT_BITS(64)) dut (
        .clk(clk), .rst(rst),
        .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read), .i_dfp_write(i_dfp_write),
        .i_dfp_wdata(i_dfp_wdata), .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
        .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
        .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory content model: beat k of a line at address a.
    function automatic logic [63:0] beat(input logic [31:0] a, input int k);
        logic [7:0] b;
        b = 8'(8'h11 * (k + 1));
        return {8{b}} ^ {32'd0, a};
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        return {beat(a, 3), beat(a, 2), beat(a, 1), beat(a, 0)};
    endfunction

    task automatic push(input bit d, input logic [31:0] a, input logic [255:0] l);
        sb_t e;
        e.d = d; e.addr = a; e.line = l;
        sb.push_back(e);
    endtask

    task automatic check_resp(input sb_t e);
        chk("i_resp", {255'd0, i_dfp_resp}, {255'd0, ~e.d});
        chk("d_resp", {255'd0, d_dfp_resp}, {255'd0, e.d});
    endtask

    // Serve one read burst; with nbeats<4 it stops mid-line and leaves the entry queued.
    task automatic serve_read(input int lat, input int gap, input int nbeats, output bit port_d);
        sb_t e;
        int  c;
        e = sb[0];
        c = 0;
        while (!bmem_read && c < 20) begin
            tick;
            c++;
        end
        chk("grant_lat", 256'(c), 256'd1);
        chk("rd_req", {255'd0, bmem_read}, 256'd1);
        chk("rd_no_wr", {255'd0, bmem_write}, 256'd0);
        chk("rd_addr", {224'd0, bmem_addr}, {224'd0, e.addr});
        repeat (lat) tick;
        chk("rd_req_held", {255'd0, bmem_read}, 256'd1);
        bmem_ready = 1'b1;
        tick;
        bmem_ready = 1'b0;
        chk("rd_req_drop", {255'd0, bmem_read}, 256'd0);
        for (int k = 0; k < nbeats; k++) begin
            repeat (gap) tick;
            bmem_rdata  = beat(e.addr, k);
            bmem_rvalid = 1'b1;
            tick;
            bmem_rvalid = 1'b0;
            if (k < 3) begin
                chk("no_early_resp", {254'd0, i_dfp_resp, d_dfp_resp}, 256'd0);
            end
        end
        port_d = e.d;
        if (nbeats == 4) begin
            void'(sb.pop_front());
            check_resp(e);
            if (e.d) chk("d_rdata", d_dfp_rdata, e.line);
            else     chk("i_rdata", i_dfp_rdata, e.line);
        end
    endtask

    task automatic serve_write(input bit toggle, output bit port_d);
        sb_t e;
        int  c;
        int  k;
        e = sb[0];
        c = 0;
        while (!bmem_write && !bmem_read && c < 20) begin
            tick;
            c++;
        end
        chk("grant_lat", 256'(c), 256'd1);
        chk("wr_addr", {224'd0, bmem_addr}, {224'd0, e.addr});
        k = 0;
        c = 0;
        while (k < 4 && c < 40) begin
            bmem_ready = toggle ? ((c % 2) == 0) : 1'b1;
            chk("wr_valid", {255'd0, bmem_write}, 256'd1);
            chk("wr_no_rd", {255'd0, bmem_read}, 256'd0);
            chk("wr_beat", {192'd0, bmem_wdata}, {192'd0, e.line[k*64 +: 64]});
            tick;
            if (bmem_ready) k++;
            c++;
        end
        bmem_ready = 1'b0;
        chk("wr_done", {255'd0, bmem_write}, 256'd0);
        void'(sb.pop_front());
        check_resp(e);
        port_d = e.d;
    endtask

    task automatic finish_resp;
        tick;
        chk("resp_one_cycle", {254'd0, i_dfp_resp, d_dfp_resp}, 256'd0);
    endtask

    initial begin
        bit pd;
        int ni, nd;

        rst = 1'b1;
        i_dfp_addr = '0; i_dfp_read = 1'b0; i_dfp_write = 1'b0; i_dfp_wdata = '0;
        d_dfp_addr = '0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        tick;
        tick;
        chk("rst_bmem", {219'd0, bmem_read, bmem_write, bmem_addr, bmem_wdata}, 256'd0);
        chk("rst_resp", {254'd0, i_dfp_resp, d_dfp_resp}, 256'd0);
        chk("rst_i_rdata", i_dfp_rdata, 256'd0);
        chk("rst_d_rdata", d_dfp_rdata, 256'd0);
        rst = 1'b0;
        tick;

        // I-cache read with 3-cycle acceptance latency.
        i_dfp_addr = 32'h0000_1040;
        i_dfp_read = 1'b1;
        push(1'b0, 32'h0000_1040, line_of(32'h0000_1040));
        serve_read(3, 0, 4, pd);
        i_dfp_read = 1'b0;
        finish_resp;

        // D-cache write to an unaligned address with ready toggling.
        d_dfp_addr  = 32'h0000_2008;
        d_dfp_wdata = {64'd4, 64'd3, 64'd2, 64'd1};
        d_dfp_write = 1'b1;
        push(1'b1, 32'h0000_2000, {64'd4, 64'd3, 64'd2, 64'd1});
        serve_write(1'b1, pd);
        d_dfp_write = 1'b0;
        finish_resp;

        // Stray read beats while idle must be dropped.
        bmem_rdata  = 64'hDEAD;
        bmem_rvalid = 1'b1;
        tick;
        chk("stray_no_req", {254'd0, bmem_read, bmem_write}, 256'd0);
        tick;
        bmem_rvalid = 1'b0;
        chk("stray_no_resp", {254'd0, i_dfp_resp, d_dfp_resp}, 256'd0);
        d_dfp_addr = 32'h0000_3000;
        d_dfp_read = 1'b1;
        push(1'b1, 32'h0000_3000, line_of(32'h0000_3000));
        serve_read(0, 1, 4, pd);
        d_dfp_read = 1'b0;
        finish_resp;

        // Reset after two beats of a read, then late beats, then a clean reissue.
        i_dfp_addr = 32'h0000_4000;
        i_dfp_read = 1'b1;
        push(1'b0, 32'h0000_4000, line_of(32'h0000_4000));
        serve_read(1, 0, 2, pd);
        rst = 1'b1;
        i_dfp_read = 1'b0;
        tick;
        chk("midrst_bmem", {219'd0, bmem_read, bmem_write, bmem_addr, bmem_wdata}, 256'd0);
        chk("midrst_resp", {254'd0, i_dfp_resp, d_dfp_resp}, 256'd0);
        chk("midrst_rdata", i_dfp_rdata, 256'd0);
        rst = 1'b0;
        void'(sb.pop_front());
        bmem_rdata  = 64'hDEAD;
        bmem_rvalid = 1'b1;
        tick;
        tick;
        bmem_rvalid = 1'b0;
        chk("late_beats_resp", {254'd0, i_dfp_resp, d_dfp_resp}, 256'd0);
        chk("late_beats_rdata", i_dfp_rdata, 256'd0);
        i_dfp_read = 1'b1;
        push(1'b0, 32'h0000_4000, line_of(32'h0000_4000));
        serve_read(0, 2, 4, pd);
        i_dfp_read = 1'b0;
        finish_resp;

        // Both caches read together, two requests each.
        i_dfp_addr = 32'h0000_5000;
        d_dfp_addr = 32'h0000_6000;
`ifdef CACHE_ARB_RR_EN
        push(1'b1, 32'h0000_6000, line_of(32'h0000_6000));
        push(1'b0, 32'h0000_5000, line_of(32'h0000_5000));
        push(1'b1, 32'h0000_6020, line_of(32'h0000_6020));
        push(1'b0, 32'h0000_5020, line_of(32'h0000_5020));
`else
        push(1'b1, 32'h0000_6000, line_of(32'h0000_6000));
        push(1'b1, 32'h0000_6020, line_of(32'h0000_6020));
        push(1'b0, 32'h0000_5000, line_of(32'h0000_5000));
        push(1'b0, 32'h0000_5020, line_of(32'h0000_5020));
`endif
        i_dfp_read = 1'b1;
        d_dfp_read = 1'b1;
        ni = 0;
        nd = 0;
        for (int t = 0; t < 4; t++) begin
            serve_read(0, 0, 4, pd);
            if (pd) begin
                nd++;
                if (nd < 2) d_dfp_addr = 32'h0000_6020;
                else        d_dfp_read = 1'b0;
            end else begin
                ni++;
                if (ni < 2) i_dfp_addr = 32'h0000_5020;
                else        i_dfp_read = 1'b0;
            end
            finish_resp;
        end

        // Read and write asserted together on one port: the write wins.
        i_dfp_addr  = 32'h0000_7010;
        i_dfp_wdata = {64'hA4A4, 64'hA3A3, 64'hA2A2, 64'hA1A1};
        i_dfp_read  = 1'b1;
        i_dfp_write = 1'b1;
        push(1'b0, 32'h0000_7000, {64'hA4A4, 64'hA3A3, 64'hA2A2, 64'hA1A1});
        serve_write(1'b0, pd);
        i_dfp_read  = 1'b0;
        i_dfp_write = 1'b0;
        finish_resp;
        tick;
        chk("final_idle", {254'd0, bmem_read, bmem_write}, 256'd0);
        chk("sb_empty", 256'(sb.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Memory-side stage directly below the L1 instruction and data caches. It accepts 256-bit line read/write requests on two cache downward-facing ports, arbitrates between them, and converts the granted request into a 64-bit, 4-beat burst transaction on the backing-memory port. Read beats are reassembled into a full line before the cache receives its single-cycle response. One transaction is in flight at a time.

## Interface
- LINE_BITS, 256: cache line width; must equal BEAT_BITS*4.
- BEAT_BITS, 64: memory burst beat width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_dfp_addr  in  32  I-cache line address; bits [4:0] ignored
- i_dfp_read  in  1  I-cache line read request; level, held until i_dfp_resp
- i_dfp_write  in  1  I-cache line write request; level, held until i_dfp_resp
- i_dfp_wdata  in  LINE_BITS  I-cache write line
- i_dfp_rdata  out  LINE_BITS  read line; valid only while i_dfp_resp=1
- i_dfp_resp  out  1  one-cycle completion pulse to I-cache
- d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata, d_dfp_rdata, d_dfp_resp: same as above, D-cache
- bmem_addr  out  32  burst address, line-aligned ({addr[31:5],5'b0})
- bmem_read  out  1  read request; held until accepted
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BEAT_BITS  write beat
- bmem_ready  in  1  memory accepts read request / write beat this cycle
- bmem_rdata  in  BEAT_BITS  read beat
- bmem_rvalid  in  1  read beat valid

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_BEAT, RESP.
- IDLE: if any request pending, grant one port (see Configuration), latch grant, line-aligned address and write line into registers; go to WR_BEAT if granted port's write=1, else RD_REQ. Write wins if a port asserts read and write together.
- RD_REQ: bmem_read=1, bmem_addr=latched address; on bmem_ready go to RD_WAIT, beat counter=0.
- RD_WAIT: each bmem_rvalid stores bmem_rdata into line[cnt*64 +: 64], cnt++; after beat 3 go to RESP.
- WR_BEAT: bmem_write=1, bmem_addr=latched address, bmem_wdata=wline[cnt*64 +: 64]; cnt++ only on bmem_ready; after beat 3 accepted go to RESP.
- RESP: granted port's dfp_resp=1 for exactly one cycle; both dfp_rdata outputs drive the line register (read line on reads, don't-care on writes); next state IDLE.
- Non-granted port's resp stays 0; its request stays pending and is served later.
- bmem_rvalid outside RD_WAIT is discarded; no state change.
- Beat counter 2 bits, wraps 3->0; no overflow path.
- Caches hold addr/wdata/read/write stable until resp; block latches them at grant and does not resample.

## Timing
- Reset values: all resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0; state IDLE, counter 0, grant pointer to D-cache.
- Grant: request visible in IDLE at cycle T -> bmem_read/bmem_write first high at T+1 (registered).
- Read: bmem_ready at cycle A, four rvalid beats at B0..B3 (any spacing, ≥A+1) -> dfp_resp at B3+1.
- Write: with bmem_ready constantly 1, beats at T+1..T+4, dfp_resp at T+5.
- After RESP, at least one IDLE cycle before next grant; a request still asserted in the RESP cycle is not re-granted in that cycle.
- rst mid-transaction: next cycle all outputs at reset values, state IDLE, partial line discarded, no resp issued; late memory beats are discarded.

## Configuration
- CACHE_ARB_RR_EN defined: round-robin; after each RESP pointer switches to the other port; when both pending in IDLE, pointer's port wins.
- Undefined: fixed priority, D-cache always wins when both pending (I-cache may starve under continuous D traffic).

## Test plan
- I-cache read 0x0000_1040, memory returns beats 0x11..,0x22..,0x33..,0x44.. after 3-cycle latency -> bmem_addr=0x0000_1040, i_dfp_rdata={beat3,beat2,beat1,beat0}, single-cycle i_dfp_resp, d_dfp_resp=0.
- D-cache write 0x0000_2008, wdata pattern beat k = k+1, bmem_ready toggling 1,0,1,0… -> bmem_addr=0x0000_2000, beats 1,2,3,4 in order, each held until ready, d_dfp_resp one cycle after 4th accept.
- I read and D read asserted same cycle, twice back-to-back -> with CACHE_ARB_RR_EN: D,I,D,I; without: D served until D drops, then I.
- Stray bmem_rvalid in IDLE with data 0xDEAD -> ignored; next read line contains only post-grant beats.
- rst asserted after 2 read beats -> outputs zero next cycle, no resp; reissued request completes with correct fresh line.
- Same port read+write together -> write burst issued, no read request.
